multicycle_main_controller: RTL and testbench

- Multi-cycle successor to the single-cycle RISC-V main decoder. Drives a shared-ALU, shared-memory datapath through a Moore FSM plus branch resolution.
- Parametrised memory wait states. Each memory access state holds for a programmable number of cycles.
- Sits between the IR/flag registers and the datapath muxes. The ALU decoder consumes ALU_opc unchanged.

---
 rtl/multicycle_main_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_main_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_controller.sv
// Multi-cycle RISC-V main controller: Moore FSM sequencing a shared-ALU,
// shared-memory datapath, with programmable memory wait states and branch resolution.
module multicycle_main_controller #(
  parameter int MEM_WAIT = 0,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opc_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       neg_i,
  output logic       PC_write_o,
  output logic       IR_write_o,
  output logic       Adr_src_o,
  output logic       Mem_write_o,
  output logic       Reg_write_o,
  output logic [2:0] Imm_src_o,
  output logic [1:0] ALU_src_A_o,
  output logic [1:0] ALU_src_B_o,
  output logic [1:0] ALU_opc_o,
  output logic [1:0] Result_src_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  localparam logic [6:0] OpcR    = 7'b0110011;
  localparam logic [6:0] OpcI    = 7'b0010011;
  localparam logic [6:0] OpcJalr = 7'b1100111;
  localparam logic [6:0] OpcLw   = 7'b0000011;
  localparam logic [6:0] OpcS    = 7'b0100011;
  localparam logic [6:0] OpcB    = 7'b1100011;
  localparam logic [6:0] OpcLui  = 7'b0110111;
  localparam logic [6:0] OpcJal  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    JALR      = 4'd11,
    LINK      = 4'd12,
    LUI       = 4'd13
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] waitCnt_q, waitCnt_d;
  logic          illegal_q, illegal_d;
  logic          lastCycle;
  logic          branchTaken;
  logic          pcWrite, irWrite, memWrite, regWrite;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      waitCnt_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign lastCycle = (waitCnt_q == CW'(MEM_WAIT));

  always_comb begin
    branchTaken = 1'b0;
    case (funct3_i)
      3'b000:  branchTaken = zero_i;
      3'b001:  branchTaken = ~zero_i;
      3'b100:  branchTaken = neg_i;
      3'b101:  branchTaken = ~neg_i;
      default: branchTaken = 1'b0;
    endcase
  end

  // The wait counter only runs in the three memory-hold states; every state
  // change leaves it cleared so the next visit starts its count from zero.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = '0;
    illegal_d    = illegal_q;
    pcWrite      = 1'b0;
    irWrite      = 1'b0;
    memWrite     = 1'b0;
    regWrite     = 1'b0;
    Adr_src_o    = 1'b0;
    Imm_src_o    = 3'b000;
    ALU_src_A_o  = 2'b00;
    ALU_src_B_o  = 2'b00;
    ALU_opc_o    = 2'b00;
    Result_src_o = 2'b00;
    instr_done_o = 1'b0;
    unique case (state_q)
      FETCH: begin
        ALU_src_B_o  = 2'b10;
        Result_src_o = 2'b10;
        if (lastCycle) begin
          pcWrite = 1'b1;
          irWrite = 1'b1;
          state_d = DECODE;
        end else begin
          waitCnt_d = waitCnt_q + CW'(1);
        end
      end
      DECODE: begin
        ALU_src_A_o = 2'b01;
        ALU_src_B_o = 2'b01;
        Imm_src_o   = (opc_i == OpcJal) ? 3'b011 : 3'b010;
        case (opc_i)
          OpcR:        state_d = EXEC_R;
          OpcI:        state_d = EXEC_I;
          OpcLw, OpcS: state_d = MEM_ADDR;
          OpcB:        state_d = BRANCH;
          OpcJal:      state_d = JAL;
          OpcJalr:     state_d = JALR;
          OpcLui:      state_d = LUI;
          default: begin
            state_d      = FETCH;
            illegal_d    = 1'b1;
            instr_done_o = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        ALU_src_A_o = 2'b10;
        ALU_opc_o   = 2'b10;
        state_d     = ALU_WB;
      end
      EXEC_I: begin
        ALU_src_A_o = 2'b10;
        ALU_src_B_o = 2'b01;
        ALU_opc_o   = 2'b11;
        state_d     = ALU_WB;
      end
      MEM_ADDR: begin
        ALU_src_A_o = 2'b10;
        ALU_src_B_o = 2'b01;
        Imm_src_o   = (opc_i == OpcS) ? 3'b001 : 3'b000;
        state_d     = (opc_i == OpcS) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        Adr_src_o = 1'b1;
        if (lastCycle) state_d = MEM_WB;
        else           waitCnt_d = waitCnt_q + CW'(1);
      end
      MEM_WB: begin
        Result_src_o = 2'b01;
        regWrite     = 1'b1;
        instr_done_o = 1'b1;
        state_d      = FETCH;
      end
      MEM_WRITE: begin
        Adr_src_o = 1'b1;
        memWrite  = 1'b1;
        if (lastCycle) begin
          instr_done_o = 1'b1;
          state_d      = FETCH;
        end else begin
          waitCnt_d = waitCnt_q + CW'(1);
        end
      end
      ALU_WB: begin
        regWrite     = 1'b1;
        instr_done_o = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        ALU_src_A_o  = 2'b10;
        ALU_opc_o    = 2'b01;
        pcWrite      = branchTaken;
        instr_done_o = 1'b1;
        state_d      = FETCH;
      end
      JAL: begin
        ALU_src_A_o = 2'b01;
        ALU_src_B_o = 2'b10;
        pcWrite     = 1'b1;
        state_d     = ALU_WB;
      end
      JALR: begin
        ALU_src_A_o  = 2'b10;
        ALU_src_B_o  = 2'b01;
        Result_src_o = 2'b10;
        pcWrite      = 1'b1;
        state_d      = LINK;
      end
      LINK: begin
        ALU_src_A_o  = 2'b01;
        ALU_src_B_o  = 2'b10;
        Result_src_o = 2'b10;
        regWrite     = 1'b1;
        instr_done_o = 1'b1;
        state_d      = FETCH;
      end
      LUI: begin
        Imm_src_o    = 3'b100;
        Result_src_o = 2'b11;
        regWrite     = 1'b1;
        instr_done_o = 1'b1;
        state_d      = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset forces FETCH asynchronously; masking the enables keeps that cycle write-free.
  assign PC_write_o  = pcWrite  & ~rst;
  assign IR_write_o  = irWrite  & ~rst;
  assign Mem_write_o = memWrite & ~rst;
  assign Reg_write_o = regWrite & ~rst;
  assign illegal_o   = illegal_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Scoreboard bench for multicycle_main_controller: three instances (MEM_WAIT 0, 2, 3)
// checked cycle by cycle against hand-written expected control words.
module tb_multicycle_main_controller;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MADDR = 4'd2,  S_MREAD = 4'd3;
  localparam logic [3:0] S_MWB   = 4'd4,  S_MWRITE = 4'd5,  S_EXR   = 4'd6,  S_EXI   = 4'd7;
  localparam logic [3:0] S_ALUWB = 4'd8,  S_BRANCH = 4'd9,  S_JAL   = 4'd10, S_JALR  = 4'd11;
  localparam logic [3:0] S_LINK  = 4'd12, S_LUI    = 4'd13;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_S = 7'b0100011, OP_B = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_JAL = 7'b1101111, OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] opc;
  logic [2:0] funct3;
  logic zero, neg;
  int sel;

  logic [21:0] w0, w2, w3, obsWord;
  logic [21:0] expQ[$];
  string tagQ[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // All three instances share stimulus; only the selected one is scored.
  multicycle_main_controller #(.MEM_WAIT(0), .CW(4)) dut0 (
    .clk(clk), .rst(rst), .opc_i(opc), .funct3_i(funct3), .zero_i(zero), .neg_i(neg),
    .PC_write_o(w0[21]), .IR_write_o(w0[20]), .Adr_src_o(w0[19]), .Mem_write_o(w0[18]),
    .Reg_write_o(w0[17]), .Imm_src_o(w0[16:14]), .ALU_src_A_o(w0[13:12]),
    .ALU_src_B_o(w0[11:10]), .ALU_opc_o(w0[9:8]), .Result_src_o(w0[7:6]),
    .instr_done_o(w0[5]), .illegal_o(w0[4]), .state_o(w0[3:0]));

  multicycle_main_controller #(.MEM_WAIT(2), .CW(4)) dut2 (
    .clk(clk), .rst(rst), .opc_i(opc), .funct3_i(funct3), .zero_i(zero), .neg_i(neg),
    .PC_write_o(w2[21]), .IR_write_o(w2[20]), .Adr_src_o(w2[19]), .Mem_write_o(w2[18]),
    .Reg_write_o(w2[17]), .Imm_src_o(w2[16:14]), .ALU_src_A_o(w2[13:12]),
    .ALU_src_B_o(w2[11:10]), .ALU_opc_o(w2[9:8]), .Result_src_o(w2[7:6]),
    .instr_done_o(w2[5]), .illegal_o(w2[4]), .state_o(w2[3:0]));

  multicycle_main_controller #(.MEM_WAIT(3), .CW(4)) dut3 (
    .clk(clk), .rst(rst), .opc_i(opc), .funct3_i(funct3), .zero_i(zero), .neg_i(neg),
    .PC_write_o(w3[21]), .IR_write_o(w3[20]), .Adr_src_o(w3[19]), .Mem_write_o(w3[18]),
    .Reg_write_o(w3[17]), .Imm_src_o(w3[16:14]), .ALU_src_A_o(w3[13:12]),
    .ALU_src_B_o(w3[11:10]), .ALU_opc_o(w3[9:8]), .Result_src_o(w3[7:6]),
    .instr_done_o(w3[5]), .illegal_o(w3[4]), .state_o(w3[3:0]));

  always_comb begin
    obsWord = w0;
    if (sel == 2) obsWord = w2;
    else if (sel == 3) obsWord = w3;
  end

  function automatic logic [21:0] ev(input logic [3:0] st, input logic pcw, input logic irw,
                                     input logic adr, input logic mw, input logic rw,
                                     input logic [2:0] imm, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] alu,
                                     input logic [1:0] res, input logic done, input logic ill);
    return {pcw, irw, adr, mw, rw, imm, a, b, alu, res, done, ill, st};
  endfunction

  function automatic logic [21:0] fetchE(input logic ill, input logic last);
    return ev(S_FETCH, last, last, 0, 0, 0, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 0, ill);
  endfunction

  function automatic logic [21:0] decodeE(input logic ill, input logic [2:0] imm);
    return ev(S_DECODE, 0, 0, 0, 0, 0, imm, 2'b01, 2'b01, 2'b00, 2'b00, 0, ill);
  endfunction

  function automatic logic [21:0] aluWbE(input logic ill);
    return ev(S_ALUWB, 0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1, ill);
  endfunction

  function automatic logic [21:0] branchE(input logic taken);
    return ev(S_BRANCH, taken, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 2'b01, 2'b00, 1, 0);
  endfunction

  // Queue the expected word for the current cycle, then advance one clock.
  task automatic applyStimulus(input string tag, input logic [21:0] e);
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input logic [21:0] e, input string tag);
    checks++;
    if (obsWord !== e) begin
      errors++;
      $display("[TB] FAIL %s: dut%0d got %h, expected %h", tag, sel, obsWord, e);
    end
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    applyStimulus(tag, ev(S_FETCH, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0));
    rst = 1'b0;
  endtask

  task automatic runR(input string tag, input logic ill);
    opc = OP_R;
    applyStimulus({tag, "_fetch"}, fetchE(ill, 1));
    applyStimulus({tag, "_decode"}, decodeE(ill, 3'b010));
    applyStimulus({tag, "_execR"}, ev(S_EXR, 0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 2'b10, 2'b00, 0, ill));
    applyStimulus({tag, "_aluWb"}, aluWbE(ill));
  endtask

  task automatic runBranch(input string tag, input logic [2:0] f3, input logic z,
                           input logic n, input logic taken);
    opc = OP_B; funct3 = f3; zero = z; neg = n;
    applyStimulus({tag, "_fetch"}, fetchE(0, 1));
    applyStimulus({tag, "_decode"}, decodeE(0, 3'b010));
    applyStimulus({tag, "_branch"}, branchE(taken));
    zero = 1'b0; neg = 1'b0; funct3 = 3'b000;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front(), tagQ.pop_front());
    end
  end

  initial begin
    rst = 1'b1; opc = OP_R; funct3 = 3'b000; zero = 1'b0; neg = 1'b0; sel = 0;
    @(posedge clk);
    #1;

    doReset("reset0");
    runR("rtype", 0);

    opc = OP_I;
    applyStimulus("itype_fetch", fetchE(0, 1));
    applyStimulus("itype_decode", decodeE(0, 3'b010));
    applyStimulus("itype_execI", ev(S_EXI, 0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 2'b11, 2'b00, 0, 0));
    applyStimulus("itype_aluWb", aluWbE(0));

    runBranch("beq_z1", 3'b000, 1, 0, 1);
    runBranch("bne_z1", 3'b001, 1, 0, 0);
    runBranch("blt_n1", 3'b100, 0, 1, 1);
    runBranch("bge_n1", 3'b101, 0, 1, 0);
    runBranch("f3_010", 3'b010, 1, 1, 0);

    opc = OP_JAL;
    applyStimulus("jal_fetch", fetchE(0, 1));
    applyStimulus("jal_decode", decodeE(0, 3'b011));
    applyStimulus("jal_jal", ev(S_JAL, 1, 0, 0, 0, 0, 3'b000, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0));
    applyStimulus("jal_aluWb", aluWbE(0));

    opc = OP_JALR;
    applyStimulus("jalr_fetch", fetchE(0, 1));
    applyStimulus("jalr_decode", decodeE(0, 3'b010));
    applyStimulus("jalr_jalr", ev(S_JALR, 1, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 2'b00, 2'b10, 0, 0));
    applyStimulus("jalr_link", ev(S_LINK, 0, 0, 0, 0, 1, 3'b000, 2'b01, 2'b10, 2'b00, 2'b10, 1, 0));

    opc = OP_LUI;
    applyStimulus("lui_fetch", fetchE(0, 1));
    applyStimulus("lui_decode", decodeE(0, 3'b010));
    applyStimulus("lui_lui", ev(S_LUI, 0, 0, 0, 0, 1, 3'b100, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0));

    opc = OP_S;
    applyStimulus("sw0_fetch", fetchE(0, 1));
    applyStimulus("sw0_decode", decodeE(0, 3'b010));
    applyStimulus("sw0_maddr", ev(S_MADDR, 0, 0, 0, 0, 0, 3'b001, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0));
    applyStimulus("sw0_mwrite", ev(S_MWRITE, 0, 0, 1, 1, 0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));

    opc = OP_BAD;
    applyStimulus("bad_fetch", fetchE(0, 1));
    applyStimulus("bad_decode", ev(S_DECODE, 0, 0, 0, 0, 0, 3'b010, 2'b01, 2'b01, 2'b00, 2'b00, 1, 0));
    runR("sticky1", 1);
    runR("sticky2", 1);
    doReset("reset0_clr");
    runR("cleared", 0);

    sel = 2;
    doReset("reset2");
    opc = OP_LW;
    applyStimulus("lw_fetch1", fetchE(0, 0));
    applyStimulus("lw_fetch2", fetchE(0, 0));
    applyStimulus("lw_fetch3", fetchE(0, 1));
    applyStimulus("lw_decode", decodeE(0, 3'b010));
    applyStimulus("lw_maddr", ev(S_MADDR, 0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0));
    for (int i = 1; i <= 3; i++)
      applyStimulus($sformatf("lw_mread%0d", i),
                    ev(S_MREAD, 0, 0, 1, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    applyStimulus("lw_mwb", ev(S_MWB, 0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0));
    applyStimulus("lw_nextFetch", fetchE(0, 0));

    sel = 3;
    doReset("reset3");
    opc = OP_S;
    for (int i = 1; i <= 4; i++) applyStimulus($sformatf("sw3_fetch%0d", i), fetchE(0, i == 4));
    applyStimulus("sw3_decode", decodeE(0, 3'b010));
    applyStimulus("sw3_maddr", ev(S_MADDR, 0, 0, 0, 0, 0, 3'b001, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0));
    for (int i = 1; i <= 4; i++)
      applyStimulus($sformatf("sw3_mwrite%0d", i),
                    ev(S_MWRITE, 0, 0, 1, 1, 0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, i == 4, 0));
    for (int i = 1; i <= 4; i++) applyStimulus($sformatf("swr_fetch%0d", i), fetchE(0, i == 4));
    applyStimulus("swr_decode", decodeE(0, 3'b010));
    applyStimulus("swr_maddr", ev(S_MADDR, 0, 0, 0, 0, 0, 3'b001, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0));
    for (int i = 1; i <= 2; i++)
      applyStimulus($sformatf("swr_mwrite%0d", i),
                    ev(S_MWRITE, 0, 0, 1, 1, 0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    doReset("rst_midWrite");
    opc = OP_R;
    for (int i = 1; i <= 4; i++) applyStimulus($sformatf("post_fetch%0d", i), fetchE(0, i == 4));
    applyStimulus("post_decode", decodeE(0, 3'b010));

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: %0d left, expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
